// File: rtl/pe_pkg.sv
// Shared types, Q-format constants and the saturation helper for the pe_mac processing element.
package pe_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_MUL = 2'b01,
        OP_MAC = 2'b10,
        OP_CLR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ACT_NONE = 2'b00,
        ACT_RELU = 2'b01,
        ACT_SIGM = 2'b10,
        ACT_RSVD = 2'b11
    } act_e;

    localparam int unsigned FRAC_DEFAULT = 16;
    localparam int unsigned ONE          = 1 << FRAC_DEFAULT;
    localparam int unsigned FOUR         = 4 << FRAC_DEFAULT;

    // Working width for clamping; must exceed every width that gets clamped.
    localparam int unsigned SAT_MAX_W = 160;

    // Clamp a signed value to the range of a w-bit signed number; hit flags a clamp.
    function automatic logic signed [SAT_MAX_W-1:0] sat_clamp(
        input  logic signed [SAT_MAX_W-1:0] x,
        input  int unsigned                 w,
        output logic                        hit
    );
        logic signed [SAT_MAX_W-1:0] hi;
        logic signed [SAT_MAX_W-1:0] lo;
        hi  = (SAT_MAX_W'(1) <<< (w - 1)) - SAT_MAX_W'(1);
        lo  = ~hi;
        hit = 1'b0;
        if (x > hi) begin
            hit = 1'b1;
            return hi;
        end
        if (x < lo) begin
            hit = 1'b1;
            return lo;
        end
        return x;
    endfunction

endpackage

// File: rtl/pe_act.sv
// Combinational activation stage: pass-through, ReLU, or piecewise-linear sigmoid.
module pe_act
    import pe_pkg::*;
#(
    parameter int unsigned OP_W = 32,
    parameter int unsigned FRAC = FRAC_DEFAULT
) (
    input  logic signed [OP_W-1:0] x,
    input  act_e                   act,
    output logic signed [OP_W-1:0] y
);

    localparam logic signed [OP_W-1:0] Q_ONE  = OP_W'(64'(1) << FRAC);
    localparam logic signed [OP_W-1:0] Q_HALF = OP_W'(64'(1) << (FRAC - 1));
    localparam logic signed [OP_W-1:0] Q_FOUR = OP_W'(64'(4) << FRAC);

    always_comb begin
        y = x;
        case (act)
            ACT_RELU: begin
                if (x < 0) y = '0;
            end
            ACT_SIGM: begin
                if (x <= -Q_FOUR)     y = '0;
                else if (x >= Q_FOUR) y = Q_ONE;
                else                  y = Q_HALF + (x >>> 3);
            end
            default: y = x;
        endcase
    end

endmodule

// File: rtl/pe_mac.sv
// Two-stage fixed-point ADD/MUL/MAC processing element with saturation and activation.
module pe_mac
    import pe_pkg::*;
#(
    parameter int unsigned OP_W  = 32,
    parameter int unsigned FRAC  = FRAC_DEFAULT,
    parameter int unsigned ACC_W = 2 * OP_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [1:0]             op,
    input  logic [1:0]             act,
    input  logic signed [OP_W-1:0] a,
    input  logic signed [OP_W-1:0] b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic signed [OP_W-1:0] res,
    output logic                   sat
);

    logic                    advance;
    logic                    v1;
    op_e                     op1;
    act_e                    act1;
    logic signed [OP_W-1:0]  a1;
    logic signed [OP_W-1:0]  b1;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_nxt;
    logic signed [2*OP_W-1:0] prod;
    logic signed [SAT_MAX_W-1:0] sum_x;
    logic signed [SAT_MAX_W-1:0] mul_x;
    logic signed [SAT_MAX_W-1:0] mac_x;
    logic signed [OP_W-1:0]  pre;
    logic signed [OP_W-1:0]  post;
    logic                    hit_a;
    logic                    hit_o;
    logic                    flag;

    // The whole pipe moves together; the input is free whenever the output slot drains.
    assign advance  = ~out_valid | out_ready;
    assign in_ready = advance;

    // Arithmetic on the S1 beat; the accumulator feeds straight in, so back-to-back MACs chain.
    always_comb begin
        prod    = (2*OP_W)'(a1) * (2*OP_W)'(b1);
        sum_x   = SAT_MAX_W'(a1) + SAT_MAX_W'(b1);
        mul_x   = SAT_MAX_W'(prod >>> FRAC);
        mac_x   = SAT_MAX_W'(acc) + mul_x;
        hit_a   = 1'b0;
        hit_o   = 1'b0;
        acc_nxt = acc;
        pre     = '0;
        case (op1)
            OP_ADD: pre = OP_W'(sat_clamp(sum_x, OP_W, hit_o));
            OP_MUL: pre = OP_W'(sat_clamp(mul_x, OP_W, hit_o));
            OP_MAC: begin
                acc_nxt = ACC_W'(sat_clamp(mac_x, ACC_W, hit_a));
                pre     = OP_W'(sat_clamp(SAT_MAX_W'(acc_nxt), OP_W, hit_o));
            end
            default: acc_nxt = '0;
        endcase
        flag = hit_a | hit_o;
    end

    pe_act #(
        .OP_W (OP_W),
        .FRAC (FRAC)
    ) u_act (
        .x   (pre),
        .act (act1),
        .y   (post)
    );

    // S1 operand capture, S2 result register and accumulator commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1        <= 1'b0;
            op1       <= OP_ADD;
            act1      <= ACT_NONE;
            a1        <= '0;
            b1        <= '0;
            out_valid <= 1'b0;
            res       <= '0;
            sat       <= 1'b0;
            acc       <= '0;
        end else if (advance) begin
            v1        <= in_valid;
            out_valid <= v1;
            if (in_valid) begin
                op1  <= op_e'(op);
                act1 <= act_e'(act);
                a1   <= a;
                b1   <= b;
            end
            if (v1) begin
                res <= (op1 == OP_CLR) ? '0 : post;
                sat <= flag;
                acc <= acc_nxt;
            end
        end
    end

endmodule
